ssp_host_arbiter: RTL and testbench
===================================

# ssp_host_arbiter

Round-robin arbiter that shares one SSP host port (PSEL/PWRITE/PWDATA/PRDATA) among NREQ on-chip requesters. Each requester posts a single-byte write (Tx) or read (Rx) request; the arbiter serialises these into SSP bus cycles. It throttles writes on SSPTXINTR and prioritises reads when SSPRXINTR signals a full Rx FIFO. The block sits between the requesters and the SSP in the same PCLK domain.

## Interface
- NREQ, 4, number of requesters (2..8)
- PCLK  in  1  clock; all logic on rising edge
- CLEAR  in  1  synchronous, active-high reset
- REQ  in  NREQ  per-requester request; held until that requester's GNT
- REQ_WR  in  NREQ  1 = write request, 0 = read; stable while REQ high
- REQ_WDATA  in  8*NREQ  write byte, requester i at [8i+7:8i]; stable while REQ high
- GNT  out  NREQ  one-hot, one-cycle pulse: transfer for that requester complete
- RVALID  out  NREQ  one-hot, one-cycle pulse with GNT on read completion
- RDATA  out  8  read byte, valid while RVALID nonzero, held otherwise
- BUSY  out  1  high in any state other than IDLE
- PSEL  out  1  SSP chip select
- PWRITE  out  1  SSP write strobe
- PWDATA  out  8  SSP write data
- PRDATA  in  8  SSP read data, valid the cycle after a read PSEL
- SSPTXINTR  in  1  SSP Tx FIFO full
- SSPRXINTR  in  1  SSP Rx FIFO full

## Operation
- All outputs registered. Reset values: GNT=0, RVALID=0, RDATA=0, BUSY=0, PSEL=0, PWRITE=0, PWDATA=0; state=IDLE; round-robin pointer LAST=NREQ-1.
- States: IDLE, XFER, CAPT, DONE.
- Eligibility (sampled in IDLE): requester i eligible if REQ[i]=1 and (REQ_WR[i]=0 or SSPTXINTR=0).
- Priority: if SSPRXINTR=1 and any eligible read exists, only eligible reads compete; otherwise all eligible requesters compete.
- Winner: first competing index scanning LAST+1, LAST+2, ... modulo NREQ. LAST<=winner on the IDLE->XFER edge.
- IDLE -> XFER when a winner exists; winner index, direction and data latched. Otherwise remain IDLE.
- XFER (one cycle): PSEL=1, PWRITE=latched REQ_WR, PWDATA=latched byte (0 on read). Write: GNT[w]=1 this cycle, next state DONE. Read: next state CAPT.
- CAPT (read only): PSEL=0; RDATA<=PRDATA at end of cycle; next state DONE.
- DONE: PSEL=0. After a read, GNT[w]=RVALID[w]=1 and RDATA valid this cycle. Next state IDLE.
- PSEL is high for exactly one cycle per transfer, never in consecutive cycles.
- Once in XFER, the transfer is committed; REQ changes have no effect until IDLE.
- Requester contract: REQ[i] low by the cycle after GNT[i]. The DONE/IDLE spacing guarantees no double grant.
- REQ withdrawn while in IDLE before winning: no transfer, no GNT.
- SSPTXINTR cannot rise between arbitration and XFER because only this block writes the SSP. The SSPTXINTR check is done only in IDLE.
- CLEAR mid-transfer: next cycle all outputs and state return to reset values; the in-flight transfer is abandoned with no GNT. A PSEL already issued is not retracted.

## Timing
- Write: IDLE decision at t0, PSEL+PWRITE+GNT at t1, DONE at t2, IDLE at t3. Peak 1 write per 3 cycles.
- Read: decision at t0, PSEL at t1, PRDATA sampled at end of t2, RDATA+RVALID+GNT at t3, IDLE at t4. Peak 1 read per 4 cycles.
- Request to grant latency with no contention: 1 cycle (write), 3 cycles (read).
- Worst-case wait for a continuously eligible requester: NREQ-1 other transfers, excluding SSPRXINTR read preemption of writes.

## Test plan
- Reset: assert CLEAR with REQ=4'b1111 -> all outputs 0, BUSY=0. Release -> requester 0 granted first (LAST=3).
- Round-robin writes: REQ=4'b1111, all writes, bytes 0xA0..0xA3, SSPTXINTR=0. Requirements: PWDATA sequence A0,A1,A2,A3,A0; GNT one-hot; PSEL spaced 3 cycles.
- Full throttle: SSPTXINTR=1 with requester 1 write 0x55 and requester 2 read pending -> only requester 2 served. Drop SSPTXINTR -> requester 1 write at next IDLE.
- Read path: requester 3 read, PRDATA=0xC3 the cycle after PSEL -> RDATA=0xC3 with RVALID=4'b1000 and GNT=4'b1000 three cycles after the decision cycle.
- Rx-full priority: LAST=0, requester 1 write and requester 2 read, SSPRXINTR=1 -> requester 2 wins first, then requester 1.
- Reset mid-read: assert CLEAR in CAPT -> no RVALID/GNT, IDLE next cycle, LAST=3.

Source files
------------

// File: rtl/ssp_host_arbiter.sv
// ---------------------------------------------------------------------------
// ssp_host_arbiter
//
// Round-robin arbiter that lets NREQ on-chip requesters share one SSP host
// port. Each requester posts a single-byte write (Tx) or read (Rx). The
// arbiter turns these into one SSP bus cycle at a time. Writes are held back
// while the Tx FIFO is full (SSPTXINTR). Reads get priority while the Rx FIFO
// is full (SSPRXINTR). Every output is registered. Everything runs on the
// rising edge of PCLK.
//
// Ports
//   PCLK       in   clock
//   CLEAR      in   synchronous active-high reset
//   REQ        in   [NREQ]    per-requester request, held until its GNT
//   REQ_WR     in   [NREQ]    1 = write, 0 = read; stable while REQ is high
//   REQ_WDATA  in   [8*NREQ]  write byte; requester i uses [8i+7:8i]
//   GNT        out  [NREQ]    one-hot pulse: this requester's transfer is done
//   RVALID     out  [NREQ]    one-hot pulse together with GNT on a read
//   RDATA      out  [8]       read byte; valid with RVALID, held otherwise
//   BUSY       out            high whenever the FSM is not in IDLE
//   PSEL       out            SSP select, high for one cycle per transfer
//   PWRITE     out            SSP write strobe
//   PWDATA     out  [8]       SSP write data (zero when PSEL is low or on reads)
//   PRDATA     in   [8]       SSP read data, valid the cycle after a read PSEL
//   SSPTXINTR  in             SSP Tx FIFO full
//   SSPRXINTR  in             SSP Rx FIFO full
// ---------------------------------------------------------------------------
module ssp_host_arbiter #(
    parameter int NREQ = 4
) (
    input  logic              PCLK,
    input  logic              CLEAR,
    input  logic [NREQ-1:0]   REQ,
    input  logic [NREQ-1:0]   REQ_WR,
    input  logic [8*NREQ-1:0] REQ_WDATA,
    output logic [NREQ-1:0]   GNT,
    output logic [NREQ-1:0]   RVALID,
    output logic [7:0]        RDATA,
    output logic              BUSY,
    output logic              PSEL,
    output logic              PWRITE,
    output logic [7:0]        PWDATA,
    input  logic [7:0]        PRDATA,
    input  logic              SSPTXINTR,
    input  logic              SSPRXINTR
);

    localparam int LW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_CAPT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     last_q, last_d;     // round-robin pointer: most recent winner
    logic [LW-1:0]     win_q, win_d;       // requester owning the current transfer
    logic              wr_q, wr_d;         // direction of the current transfer
    logic [7:0]        wdata_q, wdata_d;   // byte for the current transfer (0 on reads)

    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   rvalid_q, rvalid_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              psel_q, psel_d;
    logic              pwrite_q, pwrite_d;
    logic [7:0]        pwdata_q, pwdata_d;

    logic [NREQ-1:0]   eligible;
    logic [NREQ-1:0]   elig_rd;
    logic [NREQ-1:0]   compete;
    logic              found;
    logic [LW-1:0]     win_idx;
    logic [LW-1:0]     cand;
    logic [7:0]        req_byte;
    logic [NREQ-1:0]   win_onehot;

    // -----------------------------------------------------------------------
    // Arbitration. This is only used in IDLE. A write is eligible only while
    // the Tx FIFO has room. When the Rx FIFO is full, only reads compete,
    // provided at least one read is eligible.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default value first. Without
        //       it, a path that does not assign a signal would infer a latch.
        eligible = REQ & (~REQ_WR | {NREQ{~SSPTXINTR}});
        elig_rd  = eligible & ~REQ_WR;
        compete  = (SSPRXINTR && (|elig_rd)) ? elig_rd : eligible;
        found    = 1'b0;
        win_idx  = last_q;
        cand     = '0;
        req_byte = '0;

        // Scan LAST+1, LAST+2, ... and wrap. The first competing index wins.
        for (int k = 1; k <= NREQ; k++) begin
            cand = LW'((int'(last_q) + k) % NREQ);
            if (!found && compete[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end

        // Take the winner's byte. A read latches zero, so PWDATA is 0 on reads.
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == LW'(i) && REQ_WR[i]) begin
                req_byte = REQ_WDATA[8*i +: 8];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Register process: FSM state, transfer context and registered outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        // NOTE: sequential state uses non-blocking assignments. Every flop then
        //       samples the values from before the edge, whatever the order
        //       of the statements.
        if (CLEAR) begin
            state_q  <= S_IDLE;
            last_q   <= LW'(NREQ - 1);
            win_q    <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            psel_q   <= 1'b0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            win_q    <= win_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            psel_q   <= psel_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. The transfer context is latched on IDLE->XFER. After
    // that the transfer is committed: REQ is ignored until the FSM is back
    // in IDLE.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_XFER;
                    last_d  = win_idx;
                    win_d   = win_idx;
                    wr_d    = REQ_WR[win_idx];
                    wdata_d = req_byte;
                end
            end
            S_XFER:  state_d = wr_q ? S_DONE : S_CAPT;
            S_CAPT:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic. The outputs are registered, so this block computes the
    // values for the next cycle from the state transition that is about to
    // happen. A write is granted in its PSEL cycle. A read is granted once
    // PRDATA has been captured at the end of CAPT.
    // -----------------------------------------------------------------------
    always_comb begin
        win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win_d;
        gnt_d      = '0;
        rvalid_d   = '0;
        rdata_d    = rdata_q;
        busy_d     = (state_d != S_IDLE);
        psel_d     = 1'b0;
        pwrite_d   = 1'b0;
        pwdata_d   = '0;

        if (state_q == S_IDLE && state_d == S_XFER) begin
            psel_d   = 1'b1;
            pwrite_d = wr_d;
            pwdata_d = wdata_d;
            if (wr_d) begin
                gnt_d = win_onehot;
            end
        end

        if (state_q == S_CAPT) begin
            rdata_d  = PRDATA;
            gnt_d    = win_onehot;
            rvalid_d = win_onehot;
        end
    end

    assign GNT    = gnt_q;
    assign RVALID = rvalid_q;
    assign RDATA  = rdata_q;
    assign BUSY   = busy_q;
    assign PSEL   = psel_q;
    assign PWRITE = pwrite_q;
    assign PWDATA = pwdata_q;

endmodule

// File: tb/tb_ssp_host_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ssp_host_arbiter
//
// Self-checking bench for ssp_host_arbiter with NREQ = 4. The test tasks post
// requests and push the expected outcome (winner, direction, byte) to a
// scoreboard in the order the requests should be served. A monitor records
// every GNT pulse and every PSEL cycle. The bench pops expected and observed
// entries together and compares them. A small SSP model returns a chosen
// byte on PRDATA in the cycle after a read PSEL, and 8'hEE at all other times.
// ---------------------------------------------------------------------------
module tb_ssp_host_arbiter;

    localparam int NREQ = 4;

    logic              PCLK = 1'b0;
    logic              CLEAR;
    logic [NREQ-1:0]   REQ;
    logic [NREQ-1:0]   REQ_WR;
    logic [8*NREQ-1:0] REQ_WDATA;
    logic [NREQ-1:0]   GNT;
    logic [NREQ-1:0]   RVALID;
    logic [7:0]        RDATA;
    logic              BUSY;
    logic              PSEL;
    logic              PWRITE;
    logic [7:0]        PWDATA;
    logic [7:0]        PRDATA;
    logic              SSPTXINTR;
    logic              SSPRXINTR;

    ssp_host_arbiter #(.NREQ(NREQ)) dut (
        .PCLK      (PCLK),
        .CLEAR     (CLEAR),
        .REQ       (REQ),
        .REQ_WR    (REQ_WR),
        .REQ_WDATA (REQ_WDATA),
        .GNT       (GNT),
        .RVALID    (RVALID),
        .RDATA     (RDATA),
        .BUSY      (BUSY),
        .PSEL      (PSEL),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .SSPTXINTR (SSPTXINTR),
        .SSPRXINTR (SSPRXINTR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int         idx;
        bit         wr;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        int              cyc;
        logic [NREQ-1:0] gnt;
        logic [NREQ-1:0] rvalid;
        logic [7:0]      rdata;
    } gnt_ev_t;

    typedef struct {
        int         cyc;
        logic       pwrite;
        logic [7:0] pwdata;
    } psel_ev_t;

    exp_t     exp_q[$];
    gnt_ev_t  gnt_q[$];
    psel_ev_t psel_q[$];
    int       drained_cyc[$];

    int         cyc   = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] ssp_rd_byte = 8'h00;
    logic       rd_pending  = 1'b0;

    // Monitor and SSP read model. Both sample on the falling edge.
    always @(negedge PCLK) begin
        gnt_ev_t  ge;
        psel_ev_t pe;
        cyc = cyc + 1;
        if (GNT != '0) begin
            ge.cyc = cyc; ge.gnt = GNT; ge.rvalid = RVALID; ge.rdata = RDATA;
            gnt_q.push_back(ge);
        end
        if (PSEL) begin
            pe.cyc = cyc; pe.pwrite = PWRITE; pe.pwdata = PWDATA;
            psel_q.push_back(pe);
        end
        PRDATA     = rd_pending ? ssp_rd_byte : 8'hEE;
        rd_pending = PSEL && !PWRITE;
    end

    // Advance one cycle. Each requester drops its REQ as soon as it sees its GNT.
    task automatic tick();
        @(negedge PCLK);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (GNT[i]) REQ[i] = 1'b0;
        end
    endtask

    task automatic post(input int i, input bit wr, input logic [7:0] data);
        REQ[i]              = 1'b1;
        REQ_WR[i]           = wr;
        REQ_WDATA[8*i +: 8] = data;
    endtask

    task automatic expect_xfer(input int i, input bit wr, input logic [7:0] data);
        exp_t e;
        e.idx = i; e.wr = wr; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int w = 0;
        while (BUSY !== 1'b0 && w < 50) begin
            tick();
            w++;
        end
        n_cmp++;
        if (BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle: BUSY=%b after %0d cycles, required 0", BUSY, w);
        end
    endtask

    // Wait for n grants, then compare each one with its scoreboard entry.
    task automatic drain(input string name, input int n, input int budget);
        int              waited = 0;
        exp_t            e;
        gnt_ev_t         g;
        psel_ev_t        p;
        logic [NREQ-1:0] oh;
        logic [NREQ-1:0] rv;
        drained_cyc.delete();
        while (gnt_q.size() < n && waited < budget) begin
            tick();
            waited++;
        end
        n_cmp++;
        if (gnt_q.size() < n) begin
            n_err++;
            $display("FAIL %s timeout: got %0d grants, required %0d", name, gnt_q.size(), n);
        end
        for (int k = 0; k < n; k++) begin
            if (gnt_q.size() == 0 || exp_q.size() == 0 || psel_q.size() == 0) break;
            e  = exp_q.pop_front();
            g  = gnt_q.pop_front();
            p  = psel_q.pop_front();
            drained_cyc.push_back(g.cyc);
            oh = NREQ'(1) << e.idx;
            rv = e.wr ? '0 : oh;
            n_cmp++;
            if (g.gnt !== oh || g.rvalid !== rv) begin
                n_err++;
                $display("FAIL %s[%0d] grant: GNT=%b RVALID=%b, required GNT=%b RVALID=%b",
                         name, k, g.gnt, g.rvalid, oh, rv);
            end
            n_cmp++;
            if (p.pwrite !== e.wr || p.pwdata !== (e.wr ? e.data : 8'h00) ||
                p.cyc != g.cyc - (e.wr ? 0 : 2)) begin
                n_err++;
                $display("FAIL %s[%0d] bus: PWRITE=%b PWDATA=%h psel_cyc=%0d gnt_cyc=%0d, required PWRITE=%b PWDATA=%h offset=%0d",
                         name, k, p.pwrite, p.pwdata, p.cyc, g.cyc, e.wr,
                         e.wr ? e.data : 8'h00, e.wr ? 0 : 2);
            end
            if (!e.wr) begin
                n_cmp++;
                if (g.rdata !== e.data) begin
                    n_err++;
                    $display("FAIL %s[%0d] rdata: RDATA=%h, required %h", name, k, g.rdata, e.data);
                end
            end
        end
    endtask

    task automatic test_reset();
        CLEAR = 1'b1; SSPTXINTR = 1'b0; SSPRXINTR = 1'b0;
        REQ = '0; REQ_WR = '0; REQ_WDATA = '0;
        for (int i = 0; i < NREQ; i++) post(i, 1'b1, 8'hA0 + 8'(i));
        repeat (3) tick();
        n_cmp++;
        if ({GNT, RVALID, RDATA, BUSY, PSEL, PWRITE, PWDATA} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: GNT=%b RVALID=%b RDATA=%h BUSY=%b PSEL=%b PWRITE=%b PWDATA=%h, required all 0",
                     GNT, RVALID, RDATA, BUSY, PSEL, PWRITE, PWDATA);
        end
        gnt_q.delete();
        psel_q.delete();
        for (int i = 0; i < NREQ; i++) expect_xfer(i, 1'b1, 8'hA0 + 8'(i));
        CLEAR = 1'b0;
        drain("reset_first_grant", 1, 10);
    endtask

    task automatic test_round_robin();
        tick();
        post(0, 1'b1, 8'hA0);
        expect_xfer(0, 1'b1, 8'hA0);
        drain("round_robin", 4, 30);
        if (drained_cyc.size() == 4) begin
            for (int k = 1; k < 4; k++) begin
                n_cmp++;
                if (drained_cyc[k] - drained_cyc[k-1] != 3) begin
                    n_err++;
                    $display("FAIL rr_spacing[%0d]: %0d cycles, required 3", k,
                             drained_cyc[k] - drained_cyc[k-1]);
                end
            end
        end
    endtask

    task automatic test_write_latency();
        int t0;
        wait_idle();
        t0 = cyc;
        post(2, 1'b1, 8'h3C);
        expect_xfer(2, 1'b1, 8'h3C);
        drain("write_latency", 1, 10);
        if (drained_cyc.size() == 1) begin
            n_cmp++;
            if (drained_cyc[0] - t0 != 1) begin
                n_err++;
                $display("FAIL write_latency: %0d cycles, required 1", drained_cyc[0] - t0);
            end
        end
    endtask

    task automatic test_read_path();
        int t0;
        wait_idle();
        ssp_rd_byte = 8'hC3;
        t0 = cyc;
        post(3, 1'b0, 8'hFF);
        expect_xfer(3, 1'b0, 8'hC3);
        tick();
        n_cmp++;
        if (BUSY !== 1'b1 || PSEL !== 1'b1 || PWRITE !== 1'b0) begin
            n_err++;
            $display("FAIL read_xfer: BUSY=%b PSEL=%b PWRITE=%b, required 1 1 0", BUSY, PSEL, PWRITE);
        end
        drain("read_path", 1, 10);
        if (drained_cyc.size() == 1) begin
            n_cmp++;
            if (drained_cyc[0] - t0 != 3) begin
                n_err++;
                $display("FAIL read_latency: %0d cycles, required 3", drained_cyc[0] - t0);
            end
        end
        tick();
        n_cmp++;
        if (RDATA !== 8'hC3 || RVALID !== '0 || GNT !== '0) begin
            n_err++;
            $display("FAIL rdata_hold: RDATA=%h RVALID=%b GNT=%b, required C3 0000 0000", RDATA, RVALID, GNT);
        end
    endtask

    task automatic test_tx_throttle();
        wait_idle();
        SSPTXINTR   = 1'b1;
        ssp_rd_byte = 8'h5A;
        post(1, 1'b1, 8'h55);
        post(2, 1'b0, 8'hFF);
        expect_xfer(2, 1'b0, 8'h5A);
        drain("tx_throttle_read", 1, 10);
        repeat (6) tick();
        n_cmp++;
        if (gnt_q.size() != 0 || psel_q.size() != 0) begin
            n_err++;
            $display("FAIL tx_throttle_hold: %0d grants %0d psel, required 0 0", gnt_q.size(), psel_q.size());
        end
        SSPTXINTR = 1'b0;
        expect_xfer(1, 1'b1, 8'h55);
        drain("tx_release_write", 1, 10);
    endtask

    task automatic test_rx_priority();
        wait_idle();
        post(0, 1'b1, 8'h10);
        expect_xfer(0, 1'b1, 8'h10);
        drain("rx_prio_setup", 1, 10);
        wait_idle();
        SSPRXINTR   = 1'b1;
        ssp_rd_byte = 8'h96;
        post(1, 1'b1, 8'h11);
        post(2, 1'b0, 8'hFF);
        expect_xfer(2, 1'b0, 8'h96);
        expect_xfer(1, 1'b1, 8'h11);
        drain("rx_priority", 2, 20);
        SSPRXINTR = 1'b0;
    endtask

    task automatic test_withdraw();
        wait_idle();
        psel_q.delete();
        SSPTXINTR = 1'b1;
        post(1, 1'b1, 8'h77);
        repeat (4) tick();
        REQ[1]    = 1'b0;
        SSPTXINTR = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (gnt_q.size() != 0 || psel_q.size() != 0 || BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL withdraw: %0d grants %0d psel BUSY=%b, required 0 0 0", gnt_q.size(), psel_q.size(), BUSY);
        end
    endtask

    task automatic test_reset_mid_read();
        wait_idle();
        ssp_rd_byte = 8'h3E;
        post(1, 1'b0, 8'hFF);
        tick();
        tick();
        CLEAR  = 1'b1;
        REQ[1] = 1'b0;
        tick();
        n_cmp++;
        if (GNT !== '0 || RVALID !== '0 || BUSY !== 1'b0 || RDATA !== 8'h00 || PSEL !== 1'b0) begin
            n_err++;
            $display("FAIL clear_mid_read: GNT=%b RVALID=%b BUSY=%b RDATA=%h PSEL=%b, required 0000 0000 0 00 0",
                     GNT, RVALID, BUSY, RDATA, PSEL);
        end
        n_cmp++;
        if (gnt_q.size() != 0) begin
            n_err++;
            $display("FAIL clear_no_grant: %0d grants, required 0", gnt_q.size());
        end
        psel_q.delete();
        CLEAR = 1'b0;
        post(0, 1'b1, 8'h20);
        post(3, 1'b1, 8'h23);
        expect_xfer(0, 1'b1, 8'h20);
        expect_xfer(3, 1'b1, 8'h23);
        drain("post_clear_order", 2, 20);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_write_latency();
        test_read_path();
        test_tx_throttle();
        test_rx_priority();
        test_withdraw();
        test_reset_mid_read();
        repeat (4) tick();
        n_cmp++;
        if (exp_q.size() != 0 || gnt_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: %0d expected left, %0d grants unmatched", exp_q.size(), gnt_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
